gpio_irq_ctrl: RTL and testbench

//   Parametrised GPIO peripheral that replaces the fixed 8-bit GPIO path on the SoC top-level pads.
//   It provides a register interface for output data, direction, atomic set/clear, and synchronised input readback.
//   It also performs per-pin rising/falling edge detection with sticky write-1-to-clear status and a level interrupt to the core.

---
 rtl/gpio_irq_ctrl_if.sv | 23 ++
 rtl/gpio_irq_ctrl.sv | 113 +++++++++++
 tb/tb_gpio_irq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_ctrl_if.sv
// Register bus between a core-side master and the GPIO interrupt controller.
// Handshake: no ready/backpressure; each cycle with bus_valid high is one complete access,
// and a read answers with a one-cycle bus_rvalid pulse alongside bus_rdata on the next cycle.
interface gpio_irq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             bus_valid;
    logic             bus_we;
    logic [2:0]       bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_rvalid;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// Parametrised GPIO block: output/direction registers, atomic set/clear, synchronised input
// readback and per-pin edge detection with sticky W1C status driving a level interrupt.
module gpio_irq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gpio_irq_ctrl_if.slave     bus,
    input  logic [WIDTH-1:0]   gpio_in,
    output logic [WIDTH-1:0]   gpio_out,
    output logic [WIDTH-1:0]   gpio_oe,
    output logic               irq
);
    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;
    localparam logic [2:0] ADDR_SET     = 3'd6;
    localparam logic [2:0] ADDR_CLR     = 3'd7;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] rd_mux;

    assign wr_en    = bus.bus_valid && bus.bus_we;
    assign rd_en    = bus.bus_valid && !bus.bus_we;
    assign sync_val = sync_q[SYNC_STAGES-1];

    // Pads are sampled regardless of DIR, so driven pins loop back into edge detection.
    assign edge_evt = (sync_val & ~prev_q & rise_en_q) | (~sync_val & prev_q & fall_en_q);
    assign w1c_mask = (wr_en && bus.bus_addr == ADDR_STATUS) ? bus.bus_wdata : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_OUT:     rd_mux = out_q;
            ADDR_DIR:     rd_mux = dir_q;
            ADDR_IN:      rd_mux = sync_val;
            ADDR_RISE_EN: rd_mux = rise_en_q;
            ADDR_FALL_EN: rd_mux = fall_en_q;
            ADDR_STATUS:  rd_mux = status_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            case (bus.bus_addr)
                ADDR_OUT:     out_q     <= bus.bus_wdata;
                ADDR_DIR:     dir_q     <= bus.bus_wdata;
                ADDR_RISE_EN: rise_en_q <= bus.bus_wdata;
                ADDR_FALL_EN: fall_en_q <= bus.bus_wdata;
                ADDR_SET:     out_q     <= out_q | bus.bus_wdata;
                ADDR_CLR:     out_q     <= out_q & ~bus.bus_wdata;
                default:      ;
            endcase
        end
    end

    // A new event on a bit wins over a simultaneous W1C of that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= '0;
        else        status_q <= (status_q & ~w1c_mask) | edge_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) rdata_q <= rd_mux;
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign gpio_out       = out_q;
    assign gpio_oe        = dir_q;
    assign irq            = |status_q;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: inputs change on the falling edge, outputs are
// checked on the falling edge, read data is matched against an expected queue.
module tb_gpio_irq_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] drv_in;
    logic             loop_en;
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    logic [WIDTH-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    gpio_irq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    assign pad_in = loop_en ? gpio_out : drv_in;

    gpio_irq_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .gpio_in  (pad_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: entered just after a falling edge, return just after the next one.
    task automatic idle();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [WIDTH-1:0] data);
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = addr;
        bus.bus_wdata = data;
        @(negedge clk);
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = addr;
        @(negedge clk);
        bus.bus_valid = 1'b0;
        check($sformatf("rvalid_a%0d", addr), {31'd0, bus.bus_rvalid}, 32'd1);
        check($sformatf("rdata_a%0d", addr), {24'd0, bus.bus_rdata}, {24'd0, exp_q.pop_front()});
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        drv_in        = '0;
        loop_en       = 1'b0;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Reset landing on a pending OUT write discards it.
        bus_write(3'd1, 8'hFF);
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = 3'd0;
        bus.bus_wdata = 8'hA5;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("rst_gpio_out", {24'd0, gpio_out}, 32'h00);
        check("rst_gpio_oe", {24'd0, gpio_oe}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rvalid", {31'd0, bus.bus_rvalid}, 32'd0);
        check("rst_rdata", {24'd0, bus.bus_rdata}, 32'h00);
        for (int a = 0; a < 8; a++) bus_read(a[2:0], 8'h00);

        // SET / CLR read-modify-write
        bus_write(3'd0, 8'h0F);
        bus_write(3'd6, 8'h30);
        bus_write(3'd7, 8'h03);
        check("setclr_gpio_out", {24'd0, gpio_out}, 32'h3C);
        bus_read(3'd0, 8'h3C);
        idle();
        check("rvalid_pulse_end", {31'd0, bus.bus_rvalid}, 32'd0);
        check("rdata_hold", {24'd0, bus.bus_rdata}, 32'h3C);
        bus_read(3'd6, 8'h00);
        bus_read(3'd7, 8'h00);

        // Input synchroniser latency
        drv_in = 8'h81;
        bus_read(3'd2, 8'h00);
        bus_read(3'd2, 8'h00);
        bus_read(3'd2, 8'h81);

        // Rising edge on pin0 -> STATUS/irq three edges later, then W1C
        drv_in = 8'h00;
        repeat (4) idle();
        bus_write(3'd3, 8'h01);
        drv_in = 8'h01;
        idle();
        check("rise_irq_e1", {31'd0, irq}, 32'd0);
        idle();
        check("rise_irq_e2", {31'd0, irq}, 32'd0);
        idle();
        check("rise_irq_e3", {31'd0, irq}, 32'd1);
        bus_read(3'd5, 8'h01);
        bus_write(3'd5, 8'h01);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        bus_read(3'd5, 8'h00);

        // Set beats a simultaneous W1C on pin7 falling edge
        drv_in = 8'h81;
        repeat (4) idle();
        bus_write(3'd4, 8'h80);
        drv_in = 8'h01;
        repeat (4) idle();
        bus_read(3'd5, 8'h80);
        drv_in = 8'h81;
        repeat (4) idle();
        drv_in = 8'h01;
        idle();
        idle();
        bus_write(3'd5, 8'h80);
        check("setwins_irq", {31'd0, irq}, 32'd1);
        bus_read(3'd5, 8'h80);
        bus_write(3'd5, 8'h80);
        check("w1c7_irq", {31'd0, irq}, 32'd0);

        // Loopback self-trigger
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'hFF);
        loop_en = 1'b1;
        repeat (4) idle();
        bus_write(3'd5, 8'hFF);
        bus_write(3'd3, 8'hFF);
        check("loop_oe", {24'd0, gpio_oe}, 32'hFF);
        bus_write(3'd0, 8'h55);
        idle();
        idle();
        check("loop_irq_e3", {31'd0, irq}, 32'd0);
        idle();
        check("loop_irq_e4", {31'd0, irq}, 32'd1);
        bus_read(3'd5, 8'h55);
        bus_write(3'd3, 8'h00);
        bus_read(3'd5, 8'h55);
        check("loop_irq_hold", {31'd0, irq}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
